// File: rtl/param_operand_queue.sv
// ---------------------------------------------------------------------------
// param_operand_queue
//
// Parametrised operand queue and controller for the calculator datapath.
// Holds up to DEPTH operands of WIDTH bits and always presents the two
// front entries to the ALU. Ops are accepted through a valid/ready handshake:
//   00 push    - append din at the back
//   01 clear   - empty the queue (error flags untouched)
//   10 combine - wait for an ALU result, drop the front pair and reinsert
//                the result at the back (RESULT_AT_FRONT=0) or front (=1)
//   11 pop     - drop the front entry
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-low reset
//   op_valid/ready  op handshake, op_ready high only while idle
//   opcode, din     op code and push operand
//   res_valid/data  ALU result strobe and value, used only while waiting
//   top_pair        {entry1, entry0}, absent entries shown as PAD
//   tail            last occupied entry, PAD when empty
//   count           occupancy, is_empty / is_full derived from it
//   err_flags       sticky errors: bit0 overflow, bit1 underflow
//   err_clr         clears err_flags (a same-cycle new error still sets)
//
// Optional build macro PARAM_OPERAND_QUEUE_STATS_EN adds two 16-bit
// wrapping counters, stat_push (successful pushes) and stat_combine
// (completed combines). They reset to 0 and are not affected by clear.
// ---------------------------------------------------------------------------
module param_operand_queue #(
  parameter int               WIDTH           = 8,
  parameter int               DEPTH           = 8,
  parameter logic [WIDTH-1:0] PAD             = {WIDTH{1'b1}},
  parameter bit               RESULT_AT_FRONT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [1:0]                 opcode,
  input  logic [WIDTH-1:0]           din,
  input  logic                       res_valid,
  input  logic [WIDTH-1:0]           res_data,
  output logic [2*WIDTH-1:0]         top_pair,
  output logic [WIDTH-1:0]           tail,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       is_empty,
  output logic                       is_full,
  output logic [1:0]                 err_flags,
  input  logic                       err_clr
`ifdef PARAM_OPERAND_QUEUE_STATS_EN
  ,
  output logic [15:0]                stat_push,
  output logic [15:0]                stat_combine
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_C   = CW'(2);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  localparam logic [1:0] OPC_PUSH    = 2'b00;
  localparam logic [1:0] OPC_CLEAR   = 2'b01;
  localparam logic [1:0] OPC_COMBINE = 2'b10;
  localparam logic [1:0] OPC_POP     = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_WAIT_RES
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [WIDTH-1:0] entries_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       errFlags_q, errFlags_d;

  logic [WIDTH-1:0] shift1 [DEPTH];
  logic [WIDTH-1:0] shift2 [DEPTH];
  logic [1:0]       errSet;
  logic             opFire;
  logic             pushOk;
  logic             combineDone;
  logic [CW-1:0]    countM1;
  logic [CW-1:0]    countM2;
  logic [WIDTH-1:0] tailSel;

  // Queue contents moved forward by one and by two slots. Pop uses the
  // single shift; combine uses the double shift (back mode) or the single
  // shift behind a new front entry (front mode).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      shift1[i] = '0;
      shift2[i] = '0;
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      shift1[i] = entries_q[i+1];
    end
    for (int i = 0; i < DEPTH - 2; i++) begin
      shift2[i] = entries_q[i+2];
    end
  end

  assign countM1 = count_q - ONE_C;
  assign countM2 = count_q - TWO_C;
  assign opFire  = op_valid && (state_q == S_IDLE);

  // Next-state logic for the controller and queue. Entries at or beyond
  // count are kept at zero, so every removal explicitly zeroes the slot it
  // vacates.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    errSet      = 2'b00;
    pushOk      = 1'b0;
    combineDone = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (opFire) begin
          case (opcode)
            OPC_PUSH: begin
              if (count_q != DEPTH_C) begin
                for (int i = 0; i < DEPTH; i++) begin
                  if (CW'(i) == count_q) entries_d[i] = din;
                end
                count_d = count_q + ONE_C;
                pushOk  = 1'b1;
              end else begin
                errSet[0] = 1'b1;
              end
            end
            OPC_CLEAR: begin
              for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
              end
              count_d = '0;
            end
            OPC_COMBINE: begin
              if (count_q >= TWO_C) begin
                state_d = S_WAIT_RES;
              end else begin
                errSet[1] = 1'b1;
              end
            end
            OPC_POP: begin
              if (count_q != '0) begin
                for (int i = 0; i < DEPTH; i++) begin
                  if (CW'(i) < countM1) begin
                    entries_d[i] = shift1[i];
                  end else if (CW'(i) == countM1) begin
                    entries_d[i] = '0;
                  end
                end
                count_d = countM1;
              end else begin
                errSet[1] = 1'b1;
              end
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end

      // Queue is frozen here; only the result strobe moves things on.
      S_WAIT_RES: begin
        if (res_valid) begin
          state_d     = S_IDLE;
          count_d     = countM1;
          combineDone = 1'b1;
          for (int i = 0; i < DEPTH; i++) begin
            if (RESULT_AT_FRONT) begin
              if (i == 0) begin
                entries_d[i] = res_data;
              end else if (CW'(i) < countM1) begin
                entries_d[i] = shift1[i];
              end else if (CW'(i) == countM1) begin
                entries_d[i] = '0;
              end
            end else begin
              if (CW'(i) < countM2) begin
                entries_d[i] = shift2[i];
              end else if (CW'(i) == countM2) begin
                entries_d[i] = res_data;
              end else if (CW'(i) == countM1) begin
                entries_d[i] = '0;
              end
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A clear request drops old flags, but an error raised in the same cycle
  // still lands.
  assign errFlags_d = (err_clr ? 2'b00 : errFlags_q) | errSet;

  // State registers; reset also abandons any combine in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      errFlags_q <= 2'b00;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      errFlags_q <= errFlags_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

`ifdef PARAM_OPERAND_QUEUE_STATS_EN
  logic [15:0] statPush_q;
  logic [15:0] statCombine_q;

  // Activity counters wrap naturally at 2^16 and survive clear ops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      statPush_q    <= '0;
      statCombine_q <= '0;
    end else begin
      if (pushOk)      statPush_q    <= statPush_q + 16'd1;
      if (combineDone) statCombine_q <= statCombine_q + 16'd1;
    end
  end

  assign stat_push    = statPush_q;
  assign stat_combine = statCombine_q;
`endif

  // Last occupied entry, or PAD for an empty queue.
  always_comb begin
    tailSel = PAD;
    for (int i = 0; i < DEPTH; i++) begin
      if ((count_q != '0) && (CW'(i) == countM1)) tailSel = entries_q[i];
    end
  end

  assign op_ready  = (state_q == S_IDLE);
  assign top_pair  = {(count_q < TWO_C) ? PAD : entries_q[1],
                      (count_q == '0)   ? PAD : entries_q[0]};
  assign tail      = tailSel;
  assign count     = count_q;
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == DEPTH_C);
  assign err_flags = errFlags_q;

endmodule

// File: doc/param_operand_queue.md
Name: param_operand_queue

Overview:
- Parametrised operand queue with controller for the calculator datapath; successor to the fixed 5x8 operand queue.
- Holds up to DEPTH operands and always presents the two front entries to the ALU.
- Runs a combine handshake: waits for the ALU result, removes the front pair and reinserts the result at the back or front.
- Adds an op handshake, occupancy count, full flag, clear op and sticky typed error flags.

Parameters:
- WIDTH, 8, operand width in bits.
- DEPTH, 8, queue capacity in entries (>=2).
- PAD, {WIDTH{1'b1}}, value shown for absent operands in top_pair and tail.
- RESULT_AT_FRONT, 0; 0 = combine result goes to the back, 1 = to index 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- op_valid  in  1  op request.
- op_ready  out  1  op accepted when op_valid && op_ready.
- opcode  in  2  00 push, 01 clear, 10 combine, 11 pop.
- din  in  WIDTH  push operand.
- res_valid  in  1  ALU result strobe, used only in WAIT_RES.
- res_data  in  WIDTH  ALU result.
- top_pair  out  2*WIDTH  {entry1, entry0}.
- tail  out  WIDTH  entry[count-1].
- count  out  $clog2(DEPTH+1)  occupancy.
- is_empty  out  1  count==0.
- is_full  out  1  count==DEPTH.
- err_flags  out  2  sticky; bit0 overflow, bit1 underflow.
- err_clr  in  1  clears err_flags.

Behaviour:
- Reset (rst==0 at a clock edge):
  - All entries 0, count 0, state IDLE, err_flags 0, op_ready 1.
  - Reset in WAIT_RES aborts the combine; a pending result is lost.
- FSM: IDLE, WAIT_RES. op_ready = (state==IDLE). All ops take effect at the accepting edge.
- push, count<DEPTH: entry[count]<=din, count+1. When full: err_flags[0]<=1, nothing else changes.
- pop, count>=1: entry[i]<=entry[i+1]; vacated entry[count-1]<=0; count-1. When empty: err_flags[1]<=1.
- clear: all entries 0, count 0. err_flags unchanged.
- combine:
  - count>=2: go to WAIT_RES; queue frozen, top_pair stable.
  - count<2: err_flags[1]<=1, stay IDLE.
- WAIT_RES:
  - res_valid low: hold.
  - res_valid high: return to IDLE and count-1.
  - RESULT_AT_FRONT=0: entry[0..count-3]<=old entry[2..count-1], entry[count-2]<=res_data.
  - RESULT_AT_FRONT=1: entry[0]<=res_data, entry[1..count-2]<=old entry[2..count-1].
  - In both modes entry[count-1]<=0.
- res_valid in IDLE is ignored.
- top_pair (combinational from registers):
  - entry1 field = PAD when count<2.
  - entry0 field = PAD when count==0.
- tail = PAD when empty.
- err_clr and a new error in the same cycle: the new error's bit is set, other bits cleared.
- Ops presented with op_ready low are not accepted and must be held by the source.
- No cycle accepts both an op and a result.

Optional Feature:
- Macro: PARAM_OPERAND_QUEUE_STATS_EN.
- Defined: adds outputs stat_push (16) and stat_combine (16).
  - stat_push counts successful pushes.
  - stat_combine counts completed combines.
  - Both wrap at 2^16, reset to 0, and are not affected by clear.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 -> count=3, top_pair=0x2211, tail=0x33, is_empty=0.
- Push DEPTH=8 values, then one more push -> is_full=1, err_flags=01, contents unchanged; err_clr -> err_flags=00.
- RESULT_AT_FRONT=0, queue {0x11,0x22,0x33}, combine, hold res_valid low 3 cycles, then res_valid with 0x33:
  - op_ready=0 during the wait;
  - afterwards queue {0x33,0x33}, count=2, top_pair=0x3333.
- RESULT_AT_FRONT=1, same stimulus with result 0x44 -> queue {0x44,0x33}, tail=0x33.
- Queue {0x05}: combine -> err_flags=10, stays IDLE, top_pair=0xFF05. Then pop twice -> count=0 and the second pop sets underflow.
- Combine accepted, rst low during WAIT_RES -> count=0, op_ready=1, a following res_valid is ignored. With the stats macro defined, stat_push increments only on successful pushes.
